// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and widths for the shared-multiplier scheduler
package mult_sched_pkg;
   typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} sched_state_t;
   localparam int N_DEF  = 8;
   localparam int ITER_W = $clog2(N_DEF);
   typedef logic port_idx_t;
endpackage

// File: rtl/mult_seq_core.sv
// mult_seq_core: signed add-shift multiplier datapath (X/A/B/M registers)
module mult_seq_core #(
   parameter int N = 8
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           load,
   input  logic           add_en,
   input  logic           sub_en,
   input  logic           shift_en,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplier,
   output logic [2*N-1:0] ab
);
   logic         r_x;
   logic [N-1:0] r_a, r_b, r_m;
   logic [N:0]   w_ext_a, w_ext_m, w_sum;

   // (N+1)-bit sign-extended add, or subtract on the final iteration
   always_comb begin
      w_ext_a = {r_a[N-1], r_a};
      w_ext_m = {r_m[N-1], r_m};
      w_sum   = sub_en ? w_ext_a - w_ext_m : w_ext_a + w_ext_m;
   end

   // operand load, conditional accumulate on B[0], arithmetic shift of {X,A,B}
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_x <= 1'b0;
         r_a <= '0;
         r_b <= '0;
         r_m <= '0;
      end else if (load) begin
         r_m <= mcand;
         r_b <= mplier;
         r_a <= '0;
         r_x <= 1'b0;
      end else if ((add_en || sub_en) && r_b[0]) begin
         r_a <= w_sum[N-1:0];
         r_x <= w_sum[N];
      end else if (shift_en) begin
         r_a <= {r_x, r_a[N-1:1]};
         r_b <= {r_a[0], r_b[N-1:1]};
      end
   end

   assign ab = {r_a, r_b};
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin sharing of one signed add-shift multiplier by two ports
module mult_share_sched
   import mult_sched_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic [1:0]     req,
   input  logic [N-1:0]   mcand0,
   input  logic [N-1:0]   mplier0,
   input  logic [N-1:0]   mcand1,
   input  logic [N-1:0]   mplier1,
   output logic [1:0]     ack,
   output logic [1:0]     done,
   output logic [2*N-1:0] prod,
   output logic           busy,
   output logic           owner
);
   localparam int IW = $clog2(N);

   sched_state_t   r_state, w_next;
   logic [IW-1:0]  r_iter;
   port_idx_t      r_last, r_owner, w_win;
   logic [1:0]     r_ack, r_done;
   logic [2*N-1:0] r_prod, w_ab;
   logic           r_busy, w_load, w_last_it;

   // winner selection, FSM next state and datapath strobes
   always_comb begin
      w_next    = r_state;
      w_win     = (req == 2'b11) ? ~r_last : req[1];
      w_load    = (r_state == IDLE) && (req != 2'b00);
      w_last_it = (r_iter == IW'(N - 1));
      case (r_state)
         IDLE:    w_next = w_load ? ADD : IDLE;
         ADD:     w_next = SHIFT;
         SHIFT:   w_next = w_last_it ? DONE : ADD;
         default: w_next = IDLE;
      endcase
   end

   mult_seq_core #(.N(N)) u_core (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .load     (w_load),
      .add_en   ((r_state == ADD) && !w_last_it),
      .sub_en   ((r_state == ADD) && w_last_it),
      .shift_en (r_state == SHIFT),
      .mcand    (w_win ? mcand1 : mcand0),
      .mplier   (w_win ? mplier1 : mplier0),
      .ab       (w_ab)
   );

   // state, iteration counter, round-robin pointer and registered outputs;
   // prod/done are registered as DONE is left so they appear together
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_iter  <= '0;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_ack   <= 2'b00;
         r_done  <= 2'b00;
         r_prod  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         r_ack   <= w_load ? (w_win ? 2'b10 : 2'b01) : 2'b00;
         r_done  <= (r_state == DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
         if (w_load) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_iter  <= '0;
         end else if (r_state == SHIFT && !w_last_it) begin
            r_iter <= r_iter + 1'b1;
         end
         if (r_state == DONE) r_prod <= w_ab;
      end
   end

   assign ack   = r_ack;
   assign done  = r_done;
   assign prod  = r_prod;
   assign busy  = r_busy;
   assign owner = r_owner;
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: randomized self-checking bench against an arithmetic model
module tb_mult_share_sched;
   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [7:0]  mcand0 = '0, mplier0 = '0, mcand1 = '0, mplier1 = '0;
   logic [1:0]  ack, done;
   logic [15:0] prod;
   logic        busy, owner;
   int          checks = 0, failures = 0;
   bit          m_last = 1'b1;

   mult_share_sched #(.N(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req),
      .mcand0(mcand0), .mplier0(mplier0), .mcand1(mcand1), .mplier1(mplier1),
      .ack(ack), .done(done), .prod(prod), .busy(busy), .owner(owner)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      req = 2'b00;
      tick();
      tick();
      Reset_n = 1'b1;
      m_last = 1'b1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done == 2'b00 && n < 40);
      if (done == 2'b00) chk("done_timeout", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_prod"}, prod, 0);
      chk({tag, "_owner"}, owner, 0);
   endtask

   task automatic do_job(input bit p, input logic [7:0] a, input logic [7:0] b);
      int n;
      if (p) begin mcand1 = a; mplier1 = b; end
      else   begin mcand0 = a; mplier0 = b; end
      req = p ? 2'b10 : 2'b01;
      tick();
      chk("ack", ack, p ? 2 : 1);
      chk("busy_hi", busy, 1);
      m_last = p;
      req = 2'b00;
      if (p) begin mcand1 = 8'($urandom); mplier1 = 8'($urandom); end
      else   begin mcand0 = 8'($urandom); mplier0 = 8'($urandom); end
      wait_done(n);
      chk("latency", n, 17);
      chk("done", done, p ? 2 : 1);
      chk("prod", prod, smul(a, b));
      chk("owner", owner, p);
      chk("busy_lo", busy, 0);
   endtask

   initial begin
      int n;
      logic [7:0] a0, b0, a1, b1;
      do_reset();
      check_zero("reset");

      do_job(1'b0, 8'h07, 8'hFD);
      chk("single_const", prod, 16'hFFEB);
      do_job(1'b1, 8'h80, 8'h80); chk("c_min_min", prod, 16'h4000);
      do_job(1'b0, 8'h80, 8'h7F); chk("c_min_max", prod, 16'hC080);
      do_job(1'b1, 8'h00, 8'h5A); chk("c_zero", prod, 16'h0000);
      do_job(1'b0, 8'h7F, 8'h7F); chk("c_max_max", prod, 16'h3F01);

      for (int i = 0; i < 16; i++)
         do_job(1'($urandom), 8'($urandom), 8'($urandom));

      do_reset();
      mcand0 = 8'd3; mplier0 = 8'd5; mcand1 = 8'hFE; mplier1 = 8'd9;
      req = 2'b11;
      tick();
      chk("sim_ack0", ack, 1);
      req = 2'b10;
      wait_done(n);
      chk("sim_lat0", n, 17);
      chk("sim_done0", done, 1);
      chk("sim_prod0", prod, 16'h000F);
      tick();
      chk("sim_ack1", ack, 2);
      req = 2'b00;
      n = 1;
      while (done == 2'b00 && n < 40) begin tick(); n++; end
      chk("sim_gap", n, 18);
      chk("sim_done1", done, 2);
      chk("sim_prod1", prod, 16'hFFEE);
      m_last = 1'b1;

      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      mcand0 = a0; mplier0 = b0; mcand1 = a1; mplier1 = b1;
      req = 2'b11;
      for (int j = 0; j < 4; j++) begin
         bit w;
         w = ~m_last;
         wait_done(n);
         if (j == 0) chk("fair_lat", n, 18);
         else        chk("fair_gap", n, 18);
         if (j == 3) req = 2'b00;
         chk("fair_owner", owner, w);
         chk("fair_done", done, w ? 2 : 1);
         chk("fair_prod", prod, w ? smul(a1, b1) : smul(a0, b0));
         m_last = w;
      end

      mcand0 = 8'd11; mplier0 = 8'd13;
      req = 2'b01;
      tick();
      chk("rst_ack", ack, 1);
      req = 2'b00;
      for (int k = 0; k < 9; k++) tick();
      chk("rst_busy_mid", busy, 1);
      Reset_n = 1'b0;
      #1;
      check_zero("abort");
      tick();
      Reset_n = 1'b1;
      m_last = 1'b1;
      n = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (done != 2'b00) n++;
      end
      chk("abort_no_done", n, 0);
      do_job(1'b0, 8'd2, 8'd2);
      chk("post_rst", prod, 16'h0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that shares one signed 8x8 add-shift multiplier between two requesters. It arbitrates requests, captures the winner's operands, and sequences the add/subtract and shift steps over the shared X/A/B register set. It returns the 16-bit product to the granted port with a done pulse. The block sits between the two client blocks and the multiplier datapath, and replaces manual Execute/ClearA_loadB sequencing.

## Interface
- `N`, default 8: operand width. The iteration count equals `N`.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-port request, level. It is held with operands stable until `ack` is seen.
- `mcand0`, `mplier0` in N each: port 0 multiplicand and multiplier, two's complement.
- `mcand1`, `mplier1` in N each: port 1 multiplicand and multiplier, two's complement.
- `ack` out 2: one-hot, 1-cycle pulse in the cycle after operand capture.
- `done` out 2: one-hot, 1-cycle pulse to the owning port when `prod` is valid.
- `prod` out 2N: signed product. It holds its value until the next `done`.
- `busy` out 1: high from capture until and including the DONE cycle.
- `owner` out 1: index of the port currently or last served.

## Operation
- **States:** IDLE, ADD, SHIFT, DONE. `iter` is a counter of width clog2(N), and `last` is a 1-bit round-robin pointer.
- **IDLE.**
  - If `req` == 0, stay in IDLE.
  - Otherwise pick the winner:
    - a single requester wins;
    - if both request, the port != `last` wins.
  - On the edge:
    - M <= winner mcand;
    - B <= winner mplier;
    - A <= 0, X <= 0, `iter` <= 0;
    - `owner` <= winner, `last` <= winner;
    - go to ADD.
- **ADD.**
  - If B[0] = 1: sum = {A[N-1],A} + {M[N-1],M}, or minus when `iter` = N-1. Then A <= sum[N-1:0] and X <= sum[N].
  - If B[0] = 0: A and X are held.
  - Go to SHIFT.
- **SHIFT.**
  - Arithmetic right shift of {X,A,B}: A <= {X, A[N-1:1]}, B <= {A[0], B[N-1:1]}. X is unchanged.
  - If `iter` = N-1, go to DONE; otherwise `iter` <= `iter`+1 and go to ADD.
- **DONE.** `prod` <= {A,B} registered on entry. `done`[`owner`] = 1. Go to IDLE.
- **Arithmetic:** all add/subtract is (N+1)-bit two's complement and overflow is discarded. The result is exact for every operand pair, including -2^(N-1) * -2^(N-1) = +2^(2N-2).
- **Requests during a job:** a request arriving while busy is held pending. The other port's pending request is granted on the first IDLE cycle.
- **Lingering request:** a requester that keeps `req` high after its `ack` is treated as issuing a new request. If the other port is also requesting, round-robin still serves the other port first.
- **Reset:** an asynchronous assertion at any time aborts the job. No `done` is issued. State returns to IDLE.

## Timing
- **Reset values:**
  - state = IDLE;
  - `ack` = 0, `done` = 0, `busy` = 0;
  - `prod` = 0, `owner` = 0;
  - `last` = 1, so port 0 wins the first tie;
  - A, B, M, X and `iter` all 0.
- **Edge numbering:** capture edge = E0. `ack` is high E0 to E1. `busy` is high E0 to E2N+1.
- **Latency:** ADD/SHIFT occupies 2N cycles (16 for N = 8). `done` and `prod` are valid E2N+1 to E2N+2, i.e. 2N+1 cycles after capture.
- **Throughput:** the earliest next capture is at E2N+2, giving 2N+2 cycles per job.
- **Operand stability:** operands need to be stable only at the capture edge. They may change once `ack` is seen.
- **Fixed latency:** latency does not depend on the operand values; ADD is never skipped.

## Structure
- **Package `mult_sched_pkg`:**
  - state enum `sched_state_t` {IDLE, ADD, SHIFT, DONE};
  - localparam `ITER_W` = $clog2(N);
  - port-index typedef.
- **Sub-module `mult_seq_core`:** holds X, A, B and M, the (N+1)-bit add/subtract, and the shift. It is driven by `load`, `add_en`, `sub_en` and `shift_en` strobes.
- **Top level `mult_share_sched`:** holds arbitration, the FSM, `iter`, and the output registers.

## Test plan
- **Single job:** after reset, port 0 requests 7 * -3 (0x07, 0xFD). Expect `ack`[0] at cycle 1, then `done`[0] 17 cycles after capture with `prod` = 0xFFEB, then `busy` low.
- **Corner products:** -128 * -128 -> 0x4000; -128 * 127 -> 0xC080; 0 * 0x5A -> 0x0000; 127 * 127 -> 0x3F01.
- **Simultaneous requests:** both ports request at the same edge after reset, port 0 with 3 * 5 and port 1 with -2 * 9. Expect port 0 served first (`prod` 0x000F). Expect port 1 captured on the next IDLE edge and `done`[1] with 0xFFEE, 18 cycles after the first `done`.
- **Fairness:** both `req` held high for 4 jobs. Expect `owner` to alternate 0, 1, 0, 1 with exactly one `done` per job.
- **Reset mid-job:** assert `Reset_n` low in the 5th SHIFT cycle. Expect all outputs 0 immediately and no `done`. After release, a new 2 * 2 job returns 0x0004.
- **Operand change after ack:** change the operands the cycle after `ack`. Expect `prod` to reflect the captured values only.
